// File: rtl/spw_cfg_pkg.sv
// Shared constants and state encoding for the SpaceWire configuration packet decoder.
package spw_cfg_pkg;

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] EOP_CODE = 8'h00;
    localparam logic [7:0] EEP_CODE = 8'h01;

    // Bit of an N-char that marks it as a control character.
    localparam int unsigned CHAR_CTRL_BIT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        TAIL,
        DISCARD,
        ISSUE
    } state_e;

endpackage

// File: rtl/cfg_pkt_decoder.sv
// Parses configuration command packets from a FWFT RX FIFO into single write/read requests;
// malformed packets are dropped and counted.
module cfg_pkt_decoder
    import spw_cfg_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 32,
    parameter int unsigned ERRW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rxf_empty_i,
    input  logic [8:0]      rxf_data_i,
    output logic            rxf_rd_o,
    output logic            cfg_req_o,
    output logic            cfg_we_o,
    output logic [AW-1:0]   cfg_addr_o,
    output logic [DW-1:0]   cfg_wdata_o,
    input  logic            cfg_ack_i,
    output logic            pkt_err_o,
    output logic [ERRW-1:0] err_cnt_o
);

    localparam int unsigned AB   = AW / 8;
    localparam int unsigned DB   = DW / 8;
    localparam int unsigned MAXB = (AB > DB) ? AB : DB;
    localparam int unsigned CW   = $clog2(MAXB + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic       pop, err;
    logic       is_ctrl, is_eop, is_eep, is_term;
    logic [7:0] code;

    assign is_ctrl = rxf_data_i[CHAR_CTRL_BIT];
    assign code    = rxf_data_i[7:0];
    assign is_eop  = is_ctrl && (code == EOP_CODE);
    assign is_eep  = is_ctrl && (code == EEP_CODE);
    // Control chars other than EOP/EEP do not end a packet; they only poison it.
    assign is_term = is_eop || is_eep;

    assign pop = !rst_i && !rxf_empty_i && (state_q != ISSUE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        err_cnt_d = err_cnt_q;
        err       = 1'b0;

        if (state_q == ISSUE) begin
            if (cfg_ack_i) state_d = IDLE;
        end else if (pop) begin
            unique case (state_q)
                IDLE: begin
                    if (!is_ctrl) begin
                        cnt_d = '0;
                        if (code == CMD_WR) begin
                            we_d    = 1'b1;
                            state_d = ADDR;
                        end else if (code == CMD_RD) begin
                            we_d    = 1'b0;
                            state_d = ADDR;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else if (!is_term) begin
                        state_d = DISCARD;
                    end
                end
                ADDR: begin
                    if (is_term) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end else if (is_ctrl) begin
                        state_d = DISCARD;
                    end else begin
                        addr_d = (addr_q << 8) | AW'(code);
                        if (cnt_q == CW'(AB - 1)) begin
                            cnt_d   = '0;
                            state_d = we_q ? DATA : TAIL;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (is_term) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end else if (is_ctrl) begin
                        state_d = DISCARD;
                    end else begin
                        wdata_d = (wdata_q << 8) | DW'(code);
                        if (cnt_q == CW'(DB - 1)) begin
                            cnt_d   = '0;
                            state_d = TAIL;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                TAIL: begin
                    if (is_eop) begin
                        state_d = ISSUE;
                    end else if (is_eep) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (err && (err_cnt_q != {ERRW{1'b1}})) err_cnt_d = err_cnt_q + ERRW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rxf_rd_o    = pop;
    assign cfg_req_o   = (state_q == ISSUE);
    assign cfg_we_o    = we_q;
    assign cfg_addr_o  = addr_q;
    assign cfg_wdata_o = wdata_q;
    assign pkt_err_o   = err;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cfg_pkt_decoder.sv
// Randomized scoreboard bench for cfg_pkt_decoder: a FIFO model feeds packets, a packet-level
// reference classifies each one, and a monitor matches requests and error pulses in order.
module tb_cfg_pkt_decoder;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned ERRW = 8;
    localparam int unsigned AB   = AW / 8;
    localparam int unsigned DB   = DW / 8;
    localparam int unsigned SAT  = (1 << ERRW) - 1;
    localparam logic [8:0]  EOP  = 9'h100;
    localparam logic [8:0]  EEP  = 9'h101;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            rxf_empty_i;
    logic [8:0]      rxf_data_i;
    logic            rxf_rd_o;
    logic            cfg_req_o;
    logic            cfg_we_o;
    logic [AW-1:0]   cfg_addr_o;
    logic [DW-1:0]   cfg_wdata_o;
    logic            cfg_ack_i;
    logic            pkt_err_o;
    logic [ERRW-1:0] err_cnt_o;

    cfg_pkt_decoder #(.DW(DW), .AW(AW), .ERRW(ERRW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rxf_empty_i(rxf_empty_i),
        .rxf_data_i (rxf_data_i),
        .rxf_rd_o   (rxf_rd_o),
        .cfg_req_o  (cfg_req_o),
        .cfg_we_o   (cfg_we_o),
        .cfg_addr_o (cfg_addr_o),
        .cfg_wdata_o(cfg_wdata_o),
        .cfg_ack_i  (cfg_ack_i),
        .pkt_err_o  (pkt_err_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] fifo_q[$];
    int         tests = 0;
    int         fails = 0;
    int         errs_exp = 0;
    int         errs_seen = 0;
    int         edge_n = 0;
    int         eop_edge = -1;
    bit         stall_en = 0;

    function automatic int sat(input int n);
        return (n > int'(SAT)) ? int'(SAT) : n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: classify a whole packet (chars up to and including its terminator).
    task automatic push_pkt(input logic [8:0] p[$]);
        exp_t e;
        int   n, need;
        bit   wr;
        foreach (p[i]) fifo_q.push_back(p[i]);
        if (p[0][8]) return;
        n  = p.size() - 1;
        wr = (p[0][7:0] == 8'h01);
        e  = '{is_err: 1, we: wr, addr: '0, wdata: '0};
        if (p[0][7:0] == 8'h01 || p[0][7:0] == 8'h02) begin
            need = 1 + AB + (wr ? DB : 0);
            if (n == need && p[n] == EOP) begin
                e.is_err = 0;
                for (int i = 0; i < int'(AB); i++) e.addr = {e.addr[AW-9:0], p[1+i][7:0]};
                if (wr)
                    for (int i = 0; i < int'(DB); i++)
                        e.wdata = {e.wdata[DW-9:0], p[1+AB+i][7:0]};
            end
        end
        if (e.is_err) errs_exp++;
        exp_q.push_back(e);
    endtask

    // cmd, first na address bytes, first nd data bytes (MSB first), extra 55s, terminator.
    task automatic send(input logic [7:0] cmd, input logic [AW-1:0] a, input int na,
                        input logic [DW-1:0] d, input int nd, input int extra,
                        input logic [8:0] term);
        logic [8:0] pk[$];
        pk.push_back({1'b0, cmd});
        for (int i = 0; i < na; i++) pk.push_back({1'b0, a[AW-1-8*i -: 8]});
        for (int i = 0; i < nd; i++) pk.push_back({1'b0, d[DW-1-8*i -: 8]});
        for (int i = 0; i < extra; i++) pk.push_back(9'h055);
        pk.push_back(term);
        push_pkt(pk);
    endtask

    task automatic send_term(input logic [8:0] term);
        logic [8:0] pk[$];
        pk.push_back(term);
        push_pkt(pk);
    endtask

    task automatic send_random();
        logic [AW-1:0] a = $urandom;
        logic [DW-1:0] d = $urandom;
        logic [8:0]    t = $urandom_range(0, 1) ? EEP : EOP;
        logic [7:0]    c;
        int            na;
        case ($urandom_range(0, 6))
            0: send(8'h01, a, AB, d, DB, 0, EOP);
            1: send(8'h02, a, AB, d, 0, 0, EOP);
            2: begin
                na = $urandom_range(0, AB);
                if ($urandom_range(0, 1))
                    send(8'h01, a, na, d, (na == int'(AB)) ? $urandom_range(0, DB - 1) : 0, 0, t);
                else
                    send(8'h02, a, (na == int'(AB)) ? AB - 1 : na, d, 0, 0, t);
            end
            3: if ($urandom_range(0, 1)) send(8'h01, a, AB, d, DB, $urandom_range(1, 3), t);
               else send(8'h02, a, AB, d, 0, $urandom_range(1, 3), t);
            4: begin
                c = 8'($urandom);
                if (c == 8'h01 || c == 8'h02) c = 8'h7F;
                send(c, a, $urandom_range(0, AB), d, 0, 0, t);
            end
            5: send(8'h01, a, AB, d, DB, 0, EEP);
            default: send_term(t);
        endcase
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || cfg_req_o) && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("drain_within_budget", 64'(n < limit), 64'd1);
        repeat (3) @(posedge clk);
    endtask

    // RX FIFO model: first-word-fall-through head, optional random empty gaps.
    initial begin
        bit         pop_now;
        logic [8:0] ch;
        rxf_empty_i = 1'b1;
        rxf_data_i  = '0;
        forever begin
            @(negedge clk);
            pop_now = rxf_rd_o && !rxf_empty_i;
            @(posedge clk);
            edge_n++;
            if (pop_now && fifo_q.size() > 0) begin
                ch = fifo_q.pop_front();
                if (ch == EOP) eop_edge = edge_n;
            end
            #1;
            rxf_empty_i = (stall_en && $urandom_range(0, 3) == 0) || fifo_q.size() == 0;
            rxf_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 9'h000;
        end
    end

    // Monitor and acknowledger.
    initial begin
        bit            seen = 0;
        bit            chk_cnt = 0;
        exp_t          e, cap;
        cfg_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                seen      = 0;
                chk_cnt   = 0;
                errs_seen = 0;
                cfg_ack_i = 1'b0;
                continue;
            end
            if (chk_cnt) begin
                chk("err_cnt_after_pulse", 64'(err_cnt_o), 64'(sat(errs_seen)));
                chk_cnt = 0;
            end
            chk("rd_only_when_nonempty_and_not_issuing", 64'(rxf_rd_o),
                64'(!rxf_empty_i && !cfg_req_o));
            if (pkt_err_o) begin
                errs_seen++;
                chk_cnt = 1;
                chk("err_pulse_expected", 64'(exp_q.size() > 0 && exp_q[0].is_err), 64'd1);
                if (exp_q.size() > 0) e = exp_q.pop_front();
            end
            if (cfg_req_o) begin
                if (!seen) begin
                    chk("req_one_cycle_after_eop", 64'(edge_n), 64'(eop_edge));
                    chk("req_expected", 64'(exp_q.size() > 0 && !exp_q[0].is_err), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("req_we", 64'(cfg_we_o), 64'(e.we));
                        chk("req_addr", 64'(cfg_addr_o), 64'(e.addr));
                        if (e.we) chk("req_wdata", 64'(cfg_wdata_o), 64'(e.wdata));
                    end
                    cap  = '{is_err: 0, we: cfg_we_o, addr: cfg_addr_o, wdata: cfg_wdata_o};
                    seen = 1;
                end else begin
                    chk("req_held_stable",
                        {31'd0, cfg_we_o, cfg_addr_o ^ cfg_wdata_o},
                        {31'd0, cap.we, cap.addr ^ cap.wdata});
                end
                cfg_ack_i = ($urandom_range(0, 2) == 0);
                if (cfg_ack_i) seen = 0;
            end else begin
                cfg_ack_i = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_req"}, 64'(cfg_req_o), 64'd0);
        chk({tag, "_we"}, 64'(cfg_we_o), 64'd0);
        chk({tag, "_addr"}, 64'(cfg_addr_o), 64'd0);
        chk({tag, "_wdata"}, 64'(cfg_wdata_o), 64'd0);
        chk({tag, "_err"}, 64'(pkt_err_o), 64'd0);
        chk({tag, "_errcnt"}, 64'(err_cnt_o), 64'd0);
        chk({tag, "_rd"}, 64'(rxf_rd_o), 64'd0);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #2 rst_i = 1'b0;

        send(8'h01, 32'h12345678, AB, 32'hDEADBEEF, DB, 0, EOP);
        send(8'h02, 32'h00000010, AB, '0, 0, 0, EOP);
        send(8'h02, 32'h00000010, AB, '0, 0, 0, EOP);
        send_term(EOP);
        send_term(EEP);
        send_term(EOP);
        drain(2000);
        chk("empty_packets_no_error", 64'(err_cnt_o), 64'd0);

        send(8'h01, 32'hAABB0000, 2, '0, 0, 0, EOP);
        send(8'h7F, 32'h01000000, 1, '0, 0, 0, EOP);
        send(8'h01, $urandom, AB, $urandom, DB, 0, EEP);
        send(8'h01, 32'hCAFE0001, AB, 32'h01020304, DB, 1, EOP);
        drain(2000);
        chk("directed_err_cnt", 64'(err_cnt_o), 64'd4);

        // Partial packet abandoned by reset.
        @(posedge clk);
        #2;
        fifo_q.push_back(9'h001);
        fifo_q.push_back(9'h011);
        fifo_q.push_back(9'h022);
        fifo_q.push_back(9'h033);
        n = 0;
        while (fifo_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("partial_packet_consumed", 64'(n < 200), 64'd1);
        @(posedge clk);
        #2 rst_i = 1'b1;
        fifo_q.delete();
        errs_exp = 0;
        repeat (2) @(posedge clk);
        check_zero_outputs("midreset");
        @(posedge clk);
        #2 rst_i = 1'b0;
        send(8'h01, 32'h0BADF00D, AB, 32'h76543210, DB, 0, EOP);
        drain(2000);

        stall_en = 1;
        for (int i = 0; i < 300; i++) send_random();
        for (int i = 0; i < 260; i++) send(8'h7F, '0, 0, '0, 0, 0, EOP);
        drain(60000);
        chk("final_err_cnt_saturated", 64'(err_cnt_o), 64'(sat(errs_exp)));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
